// File: rtl/hazard_scoreboard.sv
// Producer-side forwarding tags and load-use stall control for the ID/EX boundary.
// Optional build macro HAZARD_R0_ZERO_EN: register 0 is hardwired zero and is never tracked.
module hazard_scoreboard #(
  parameter int REG_W    = 4,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs_a,
  input  logic [REG_W-1:0]    id_rs_b,
  input  logic                id_use_a,
  input  logic                id_use_b,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_wr_en,
  input  logic                id_is_load,
  input  logic                mem_hold,
  output logic                stall_id,
  output logic                bubble_ex,
  output logic [REG_W-1:0]    ex_rd,
  output logic [REG_W-1:0]    mem_rd,
  output logic [REG_W-1:0]    wb_rd,
  output logic                ctrl_ex,
  output logic                ctrl_mem,
  output logic                ctrl_wb,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    stall_count
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic             is_load;
  } stage_t;

  stage_t           ex_q, mem_q, wb_q;
  stage_t           ex_next;
  logic [CNT_W-1:0] stall_count_q;
  logic             match_a, match_b;
  logic             new_wr_en;
  logic             hz;
  logic             unused_is_load;

  // Only a load sitting in EX is a hazard; anything older is covered by forwarding.
`ifdef HAZARD_R0_ZERO_EN
  assign match_a   = id_use_a && (id_rs_a == ex_q.rd) && (id_rs_a != '0);
  assign match_b   = id_use_b && (id_rs_b == ex_q.rd) && (id_rs_b != '0);
  assign new_wr_en = id_wr_en && id_valid && (id_rd != '0);
`else
  assign match_a   = id_use_a && (id_rs_a == ex_q.rd);
  assign match_b   = id_use_b && (id_rs_b == ex_q.rd);
  assign new_wr_en = id_wr_en && id_valid;
`endif

  assign hz = id_valid && ex_q.valid && ex_q.wr_en && ex_q.is_load && (match_a || match_b);

  always_comb begin
    ex_next.valid   = id_valid;
    ex_next.rd      = id_rd;
    ex_next.wr_en   = new_wr_en;
    ex_next.is_load = id_is_load;
  end

  // A memory hold freezes everything and outranks a hazard, so no bubble is injected.
  always_comb begin
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    if (mem_hold) begin
      stall_id = 1'b1;
    end else if (hz) begin
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else if (!mem_hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (hz) begin
        ex_q <= '0;
        if (stall_count_q != '1) begin
          stall_count_q <= stall_count_q + 1'b1;
        end
      end else begin
        ex_q <= ex_next;
      end
    end
  end

  assign ex_rd       = ex_q.rd;
  assign mem_rd      = mem_q.rd;
  assign wb_rd       = wb_q.rd;
  assign ctrl_ex     = ex_q.valid && ex_q.wr_en && !ex_q.is_load;
  assign ctrl_mem    = mem_q.valid && mem_q.wr_en;
  assign ctrl_wb     = wb_q.valid && wb_q.wr_en;
  assign stall_count = stall_count_q;

  // Load status only matters in EX; older stages keep it for completeness.
  assign unused_is_load = mem_q.is_load ^ wb_q.is_load;

  always_comb begin
    busy_vec = '0;
    if (ex_q.valid && ex_q.wr_en) busy_vec[ex_q.rd] = 1'b1;
    if (mem_q.valid && mem_q.wr_en) busy_vec[mem_q.rd] = 1'b1;
    if (wb_q.valid && wb_q.wr_en) busy_vec[wb_q.rd] = 1'b1;
`ifdef HAZARD_R0_ZERO_EN
    busy_vec[0] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed checking of hazard_scoreboard against a pipeline-list reference model.
module tb_hazard_scoreboard;

  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                id_valid = 1'b0;
  logic [REG_W-1:0]    id_rs_a = '0;
  logic [REG_W-1:0]    id_rs_b = '0;
  logic                id_use_a = 1'b0;
  logic                id_use_b = 1'b0;
  logic [REG_W-1:0]    id_rd = '0;
  logic                id_wr_en = 1'b0;
  logic                id_is_load = 1'b0;
  logic                mem_hold = 1'b0;
  logic                stall_id, bubble_ex;
  logic [REG_W-1:0]    ex_rd, mem_rd, wb_rd;
  logic                ctrl_ex, ctrl_mem, ctrl_wb;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0]    stall_count;

  hazard_scoreboard #(.REG_W(REG_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .mem_hold(mem_hold), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem),
    .ctrl_wb(ctrl_wb), .busy_vec(busy_vec), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference: a list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit valid;
    int rd;
    bit writes;
    bit is_load;
  } instr_t;

  instr_t pipe[3];
  int     model_count = 0;
  int     errors = 0;
  int     checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit readsLoadDest(int rs, bit use_it);
    if (!use_it) return 0;
    if (R0_ZERO && rs == 0) return 0;
    return rs == pipe[0].rd;
  endfunction

  function automatic bit modelHazard();
    if (!(id_valid && pipe[0].valid && pipe[0].writes && pipe[0].is_load)) return 0;
    return readsLoadDest(int'(id_rs_a), id_use_a) || readsLoadDest(int'(id_rs_b), id_use_b);
  endfunction

  task automatic checkAll(input string ph);
    bit hz;
    int busy;
    hz = modelHazard();
    busy = 0;
    for (int s = 0; s < 3; s++)
      if (pipe[s].valid && pipe[s].writes && !(R0_ZERO && pipe[s].rd == 0)) busy |= (1 << pipe[s].rd);
    if (!rst) begin
      checkOutput({ph, ".stall_id"}, 32'(stall_id), 32'(mem_hold || hz));
      checkOutput({ph, ".bubble_ex"}, 32'(bubble_ex), 32'(!mem_hold && hz));
    end
    checkOutput({ph, ".ctrl_ex"}, 32'(ctrl_ex), 32'(pipe[0].valid && pipe[0].writes && !pipe[0].is_load));
    checkOutput({ph, ".ctrl_mem"}, 32'(ctrl_mem), 32'(pipe[1].valid && pipe[1].writes));
    checkOutput({ph, ".ctrl_wb"}, 32'(ctrl_wb), 32'(pipe[2].valid && pipe[2].writes));
    checkOutput({ph, ".busy_vec"}, 32'(busy_vec), 32'(busy));
    checkOutput({ph, ".stall_count"}, 32'(stall_count), 32'(model_count));
    if (pipe[0].valid) checkOutput({ph, ".ex_rd"}, 32'(ex_rd), 32'(pipe[0].rd));
    if (pipe[1].valid) checkOutput({ph, ".mem_rd"}, 32'(mem_rd), 32'(pipe[1].rd));
    if (pipe[2].valid) checkOutput({ph, ".wb_rd"}, 32'(wb_rd), 32'(pipe[2].rd));
  endtask

  task automatic stepModel();
    bit hz;
    if (rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
      model_count = 0;
    end else if (!mem_hold) begin
      hz = modelHazard();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (hz) begin
        pipe[0] = '{0, 0, 0, 0};
        if (model_count < CNT_MAX) model_count++;
      end else begin
        pipe[0] = '{id_valid, int'(id_rd), id_valid && id_wr_en && !(R0_ZERO && id_rd == 0), id_is_load};
      end
    end
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, then advance the model across the edge.
  task automatic applyStimulus(input string ph, input bit r, input bit v, input int rs_a, input bit ua,
                               input int rs_b, input bit ub, input int rd, input bit we, input bit ld,
                               input bit hold);
    @(negedge clk);
    rst = r; id_valid = v; id_rs_a = REG_W'(rs_a); id_use_a = ua; id_rs_b = REG_W'(rs_b);
    id_use_b = ub; id_rd = REG_W'(rd); id_wr_en = we; id_is_load = ld; mem_hold = hold;
    #1;
    checkAll(ph);
    stepModel();
  endtask

  task automatic idle(input string ph);
    applyStimulus(ph, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus("rst", 1, 1, $urandom_range(0, 15), 1, $urandom_range(0, 15), 1, $urandom_range(0, 15), 1, 1, 0);
    applyStimulus("rst", 1, $urandom_range(0, 1), $urandom_range(0, 15), 1, 3, 1, 7, 1, 0, 1);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};

    doReset();
    idle("post_rst");
    checkOutput("reset.busy_vec", 32'(busy_vec), 32'h0);
    checkOutput("reset.stall_count", 32'(stall_count), 32'h0);

    // Back-to-back ALU dependency: forwarded from EX, then from MEM.
    applyStimulus("alu_wr", 0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    applyStimulus("alu_rd", 0, 1, 3, 1, 0, 0, 9, 1, 0, 0);
    checkOutput("alu.no_stall", 32'(stall_id), 32'h0);
    checkOutput("alu.ctrl_ex", 32'(ctrl_ex), 32'h1);
    checkOutput("alu.ex_rd", 32'(ex_rd), 32'h3);
    idle("alu_idle");
    checkOutput("alu.ctrl_mem", 32'(ctrl_mem), 32'h1);
    checkOutput("alu.mem_rd", 32'(mem_rd), 32'h3);

    // Load-use costs one stall, then the dependent picks the value from MEM.
    doReset();
    applyStimulus("ld", 0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus("lu_stall", 0, 1, 0, 0, 5, 1, 6, 1, 0, 0);
    checkOutput("lu.stall_id", 32'(stall_id), 32'h1);
    checkOutput("lu.bubble_ex", 32'(bubble_ex), 32'h1);
    checkOutput("lu.ctrl_ex_load", 32'(ctrl_ex), 32'h0);
    applyStimulus("lu_issue", 0, 1, 0, 0, 5, 1, 6, 1, 0, 0);
    checkOutput("lu.issue_stall", 32'(stall_id), 32'h0);
    checkOutput("lu.mem_rd", 32'(mem_rd), 32'h5);
    checkOutput("lu.ctrl_mem", 32'(ctrl_mem), 32'h1);
    checkOutput("lu.ctrl_ex", 32'(ctrl_ex), 32'h0);
    checkOutput("lu.count", 32'(stall_count), 32'h1);

    // Memory hold on top of a pending load-use freezes state without a bubble.
    doReset();
    applyStimulus("hld_ld", 0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("hold", 0, 1, 0, 0, 5, 1, 6, 1, 0, 1);
      checkOutput("hold.bubble_ex", 32'(bubble_ex), 32'h0);
    end
    applyStimulus("hold_stall", 0, 1, 0, 0, 5, 1, 6, 1, 0, 0);
    applyStimulus("hold_issue", 0, 1, 0, 0, 5, 1, 6, 1, 0, 0);
    checkOutput("hold.count", 32'(stall_count), 32'h1);

    // Chain of dependent loads to push the counter into saturation.
    doReset();
    applyStimulus("sat_ld", 0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("sat_stall", 0, 1, 1, 1, 0, 0, 1, 1, 1, 0);
      applyStimulus("sat_issue", 0, 1, 1, 1, 0, 0, 1, 1, 1, 0);
    end
    checkOutput("sat.count", 32'(stall_count), 32'(CNT_MAX));
    applyStimulus("busy_w1", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("busy_w2", 0, 1, 0, 0, 0, 0, 2, 1, 0, 0);
    applyStimulus("busy_w1b", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    idle("busy_idle");
    checkOutput("busy.vec", 32'(busy_vec), 32'h0006);

`ifdef HAZARD_R0_ZERO_EN
    doReset();
    applyStimulus("r0_ld", 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus("r0_rd", 0, 1, 0, 1, 0, 1, 4, 1, 0, 0);
    checkOutput("r0.no_stall", 32'(stall_id), 32'h0);
    checkOutput("r0.busy0", 32'(busy_vec[0]), 32'h0);
    idle("r0_idle");
    checkOutput("r0.ctrl_mem", 32'(ctrl_mem), 32'h0);
`endif

    // Random traffic over a small register range to provoke frequent hazards.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus("rnd", ($urandom_range(0, 63) == 0), ($urandom_range(0, 4) != 0),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
